psk_sweep_dispatcher: RTL and testbench

- Parametrised successor to the single-bin PSK correlator dispatcher.
- Sweeps an internal I/Q NCO across N_STEPS frequency bins. In each bin it correlates the 1-bit input against 1-bit I and Q codes for INT_LEN cycles and computes power I^2+Q^2.
- Reports per-bin power and the peak bin (FCW and power).
- Sits between the 1-bit sampled input (comparator/ADC sign) and the acquisition/telemetry logic. Supports single-shot and continuous sweep modes.

---
 rtl/psk_sweep_dispatcher.sv | 172 +++++++++++++++++
 tb/tb_psk_sweep_dispatcher.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/psk_sweep_dispatcher.sv
// psk_sweep_dispatcher: sweeps an I/Q NCO over N_STEPS frequency bins,
// correlates the 1-bit input against the NCO sign codes for INT_LEN cycles
// per bin, and reports each bin's power plus the strongest bin of the sweep.
module psk_sweep_dispatcher #(
  parameter int                 PHASE_W   = 12,
  parameter int                 INT_LEN   = 16,
  parameter int                 N_STEPS   = 4,
  parameter logic [PHASE_W-1:0] FCW_START = 12'h100,
  parameter logic [PHASE_W-1:0] FCW_STEP  = 12'h040,
  parameter int                 CORR_W    = $clog2(INT_LEN) + 2,
  parameter int                 POW_W     = 2 * CORR_W
) (
  input  logic               clk,
  input  logic               rst_in,
  input  logic               sig,
  input  logic               start,
  input  logic               continuous,
  output logic               busy,
  output logic               bin_stb,
  output logic [PHASE_W-1:0] bin_fcw,
  output logic [POW_W-1:0]   bin_power,
  output logic               stb,
  output logic [PHASE_W-1:0] peak_fcw,
  output logic [POW_W-1:0]   peak_power
);

  localparam int CNT_W = $clog2(INT_LEN);
  localparam int IDX_W = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(INT_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_STEPS - 1);

  typedef enum logic [2:0] {
    IDLE,
    INTEGRATE,
    MEASURE,
    COMPARE,
    DONE
  } state_t;

  state_t state, next_state;

  logic [PHASE_W-1:0]       phase;
  logic [PHASE_W-1:0]       fcw;
  logic [CNT_W-1:0]         cnt;
  logic [IDX_W-1:0]         idx;
  logic signed [CORR_W-1:0] i_acc, q_acc;
  logic signed [CORR_W-1:0] i_step, q_step;
  logic signed [POW_W-1:0]  i_ext, q_ext;
  logic [POW_W-1:0]         power_next;
  logic [POW_W-1:0]         best;
  logic [PHASE_W-1:0]       best_fcw;
  logic [POW_W-1:0]         best_next;
  logic [PHASE_W-1:0]       best_fcw_next;
  logic                     i_code, q_code;
  logic                     take_best;
  logic                     sweep_init;

  // NCO codes are taken from the pre-increment phase. Adding a quarter turn
  // flips bit PHASE_W-2 and carries into the MSB only when that bit was set,
  // so the Q code reduces to an XOR of the top two phase bits.
  assign i_code = phase[PHASE_W-1];
  assign q_code = phase[PHASE_W-1] ^ phase[PHASE_W-2];
  assign i_step = (sig == i_code) ? CORR_W'(1) : '1;
  assign q_step = (sig == q_code) ? CORR_W'(1) : '1;

  // Power is computed at full product width; 2*INT_LEN^2 always fits.
  assign i_ext      = {{(POW_W - CORR_W){i_acc[CORR_W-1]}}, i_acc};
  assign q_ext      = {{(POW_W - CORR_W){q_acc[CORR_W-1]}}, q_acc};
  assign power_next = i_ext * i_ext + q_ext * q_ext;

  // Bin 0 always seeds the best register; later bins need a strictly larger
  // power, so ties keep the earlier bin.
  assign take_best     = (bin_power > best) || (idx == '0);
  assign best_next     = take_best ? bin_power : best;
  assign best_fcw_next = take_best ? fcw : best_fcw;

  assign sweep_init = ((state == IDLE) && start) || ((state == DONE) && continuous);

  // State register; reset aborts any sweep in progress.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state logic and the state-decoded strobes.
  always_comb begin
    next_state = state;
    busy       = 1'b1;
    bin_stb    = 1'b0;
    stb        = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) next_state = INTEGRATE;
      end
      INTEGRATE: begin
        if (cnt == '0) next_state = MEASURE;
      end
      MEASURE: begin
        next_state = COMPARE;
      end
      COMPARE: begin
        bin_stb = 1'b1;
        if (idx == LAST_IDX) next_state = DONE;
        else                 next_state = INTEGRATE;
      end
      DONE: begin
        stb = 1'b1;
        if (continuous) next_state = INTEGRATE;
        else            next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Datapath: NCO, correlators, per-bin result and running peak.
  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      phase      <= '0;
      fcw        <= '0;
      cnt        <= '0;
      idx        <= '0;
      i_acc      <= '0;
      q_acc      <= '0;
      best       <= '0;
      best_fcw   <= '0;
      bin_fcw    <= '0;
      bin_power  <= '0;
      peak_fcw   <= '0;
      peak_power <= '0;
    end else if (sweep_init) begin
      phase    <= '0;
      fcw      <= FCW_START;
      cnt      <= CNT_LOAD;
      idx      <= '0;
      i_acc    <= '0;
      q_acc    <= '0;
      best     <= '0;
      best_fcw <= FCW_START;
    end else begin
      case (state)
        INTEGRATE: begin
          i_acc <= i_acc + i_step;
          q_acc <= q_acc + q_step;
          phase <= phase + fcw;
          if (cnt != '0) cnt <= cnt - CNT_W'(1);
        end
        MEASURE: begin
          bin_power <= power_next;
          bin_fcw   <= fcw;
        end
        COMPARE: begin
          best     <= best_next;
          best_fcw <= best_fcw_next;
          if (idx == LAST_IDX) begin
            peak_power <= best_next;
            peak_fcw   <= best_fcw_next;
          end else begin
            fcw   <= fcw + FCW_STEP;
            idx   <= idx + IDX_W'(1);
            phase <= '0;
            cnt   <= CNT_LOAD;
            i_acc <= '0;
            q_acc <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psk_sweep_dispatcher.sv
// tb_psk_sweep_dispatcher: three dispatcher instances (FCW_START 0x000,
// 0x100 and 0xFC0) driven by directed sweeps; expected bin/peak results are
// queued at stimulus time and a negedge monitor pops and compares them.
module tb_psk_sweep_dispatcher;

  logic        clk = 1'b0;
  logic        rst;
  logic        sig;
  logic        continuous;
  logic        start_v      [3];
  logic        busy_w       [3];
  logic        bin_stb_w    [3];
  logic        stb_w        [3];
  logic [11:0] bin_fcw_w    [3];
  logic [11:0] bin_power_w  [3];
  logic [11:0] peak_fcw_w   [3];
  logic [11:0] peak_power_w [3];

  longint cyc = 0;
  int     n_checks = 0;
  int     n_fail = 0;

  typedef struct {
    int          dut;
    logic [11:0] fcw;
    logic [11:0] pw;
    longint      cyc;
  } exp_t;

  typedef struct {
    string  name;
    longint act;
    longint exp;
  } chk_t;

  exp_t bin_q  [$];
  exp_t peak_q [$];
  chk_t chk_q  [$];

  // 10-unit clock period
  always #5 clk = ~clk;

  // Cycle counter; reads k during the cycle that follows the k-th posedge
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [11:0] FS = (g == 0) ? 12'h000 : (g == 1) ? 12'h100 : 12'hFC0;
    psk_sweep_dispatcher #(
      .PHASE_W(12), .INT_LEN(16), .N_STEPS(4),
      .FCW_START(FS), .FCW_STEP(12'h040)
    ) dut (
      .clk(clk), .rst_in(rst), .sig(sig), .start(start_v[g]),
      .continuous(continuous), .busy(busy_w[g]), .bin_stb(bin_stb_w[g]),
      .bin_fcw(bin_fcw_w[g]), .bin_power(bin_power_w[g]), .stb(stb_w[g]),
      .peak_fcw(peak_fcw_w[g]), .peak_power(peak_power_w[g])
    );
  end

  function automatic void checkOutput(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: compares every strobe against the scoreboard and drains
  // the queued direct checks issued by the stimulus process
  always @(negedge clk) begin : monitor
    exp_t e;
    chk_t c;
    for (int g = 0; g < 3; g++) begin
      if (bin_stb_w[g]) begin
        if (bin_q.size() == 0) checkOutput($sformatf("unexpected_bin_stb_dut%0d", g), 1, 0);
        else begin
          e = bin_q.pop_front();
          checkOutput("bin_dut", g, e.dut);
          checkOutput("bin_fcw", bin_fcw_w[g], e.fcw);
          checkOutput("bin_power", bin_power_w[g], e.pw);
          checkOutput("bin_cycle", cyc, e.cyc);
        end
      end
      if (stb_w[g]) begin
        if (peak_q.size() == 0) checkOutput($sformatf("unexpected_stb_dut%0d", g), 1, 0);
        else begin
          e = peak_q.pop_front();
          checkOutput("peak_dut", g, e.dut);
          checkOutput("peak_fcw", peak_fcw_w[g], e.fcw);
          checkOutput("peak_power", peak_power_w[g], e.pw);
          checkOutput("stb_cycle", cyc, e.cyc);
        end
      end
    end
    while (chk_q.size() > 0) begin
      c = chk_q.pop_front();
      checkOutput(c.name, c.act, c.exp);
    end
  end

  task automatic expectValue(input string name, input longint act, input longint exp);
    chk_q.push_back('{name, act, exp});
  endtask

  task automatic applyStimulus(input int g, input bit hold, output longint t);
    @(negedge clk);
    start_v[g] = 1'b1;
    t = cyc;
    @(negedge clk);
    if (!hold) start_v[g] = 1'b0;
    expectValue("busy_after_start", longint'(busy_w[g]), 1);
  endtask

  task automatic pushSweep(input int g, input longint t, input logic [11:0] fs,
                           input logic [3:0][11:0] pw, input logic [11:0] pf,
                           input logic [11:0] pp);
    for (int k = 0; k < 4; k++)
      bin_q.push_back('{g, fs + 12'(k * 64), pw[k], t + 18 + 18 * k});
    peak_q.push_back('{g, pf, pp, t + 73});
  endtask

  task automatic waitIdle(input int g, input int budget);
    int n = 0;
    while (busy_w[g] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_w[g]) expectValue("idle_timeout", 1, 0);
  endtask

  task automatic pulseAt(input int g, input longint c);
    while (cyc < c) @(negedge clk);
    start_v[g] = 1'b1;
    @(negedge clk);
    start_v[g] = 1'b0;
  endtask

  // One sweep on dut g with sig from an NCO at FCW 0x180, phase 0 per bin
  task automatic ncoSweep(input int g, input bit push);
    longint      t;
    int          m;
    logic [11:0] ph;
    applyStimulus(g, 1'b0, t);
    if (push)
      pushSweep(g, t, 12'h100, {12'd100, 12'd256, 12'd200, 12'd104}, 12'h180, 12'd256);
    while (cyc <= t + 72) begin
      m   = int'((cyc - t - 1) % 18);
      ph  = 12'(m * 384);
      sig = (m < 16) ? ph[11] : 1'b0;
      @(negedge clk);
    end
    sig = 1'b0;
  endtask

  // Watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    longint t;
    rst = 1'b1;
    sig = 1'b0;
    continuous = 1'b0;
    for (int g = 0; g < 3; g++) start_v[g] = 1'b0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      expectValue("reset_busy", longint'(busy_w[g]), 0);
      expectValue("reset_bin_fcw", longint'(bin_fcw_w[g]), 0);
      expectValue("reset_peak_fcw", longint'(peak_fcw_w[g]), 0);
    end
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] FCW_START=0, sig=0 single sweep");
    applyStimulus(0, 1'b0, t);
    pushSweep(0, t, 12'h000, {12'd52, 12'd256, 12'd512, 12'd512}, 12'h000, 12'd512);
    waitIdle(0, 200);

    $display("[TB] sig=1 with start held: back-to-back sweeps");
    sig = 1'b1;
    applyStimulus(0, 1'b1, t);
    pushSweep(0, t, 12'h000, {12'd52, 12'd256, 12'd512, 12'd512}, 12'h000, 12'd512);
    pushSweep(0, t + 74, 12'h000, {12'd52, 12'd256, 12'd512, 12'd512}, 12'h000, 12'd512);
    while (cyc < t + 75) begin
      @(negedge clk);
      if (cyc == t + 74) expectValue("held_start_idle_cycle", longint'(busy_w[0]), 0);
    end
    start_v[0] = 1'b0;
    waitIdle(0, 200);
    sig = 1'b0;

    $display("[TB] continuous mode, dropped during second sweep");
    continuous = 1'b1;
    applyStimulus(0, 1'b0, t);
    pushSweep(0, t, 12'h000, {12'd52, 12'd256, 12'd512, 12'd512}, 12'h000, 12'd512);
    pushSweep(0, t + 73, 12'h000, {12'd52, 12'd256, 12'd512, 12'd512}, 12'h000, 12'd512);
    while (cyc < t + 100) @(negedge clk);
    continuous = 1'b0;
    while (cyc < t + 146) @(negedge clk);
    expectValue("busy_in_final_done", longint'(busy_w[0]), 1);
    @(negedge clk);
    expectValue("busy_after_continuous", longint'(busy_w[0]), 0);
    waitIdle(0, 50);

    $display("[TB] NCO-driven input, default parameters");
    ncoSweep(1, 1'b1);
    waitIdle(1, 50);

    $display("[TB] asynchronous reset mid-integration");
    applyStimulus(1, 1'b0, t);
    while (cyc < t + 6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    expectValue("arst_busy", longint'(busy_w[1]), 0);
    expectValue("arst_bin_stb", longint'(bin_stb_w[1]), 0);
    expectValue("arst_stb", longint'(stb_w[1]), 0);
    expectValue("arst_bin_fcw", longint'(bin_fcw_w[1]), 0);
    expectValue("arst_bin_power", longint'(bin_power_w[1]), 0);
    expectValue("arst_peak_fcw", longint'(peak_fcw_w[1]), 0);
    expectValue("arst_peak_power", longint'(peak_power_w[1]), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ncoSweep(1, 1'b1);
    waitIdle(1, 50);

    $display("[TB] FCW wrap and ignored start pulses");
    applyStimulus(2, 1'b0, t);
    pushSweep(2, t, 12'hFC0, {12'd256, 12'd512, 12'd512, 12'd452}, 12'h000, 12'd512);
    pulseAt(2, t + 10);
    pulseAt(2, t + 40);
    pulseAt(2, t + 73);
    waitIdle(2, 50);
    repeat (3) @(negedge clk);
    expectValue("start_in_done_ignored", longint'(busy_w[2]), 0);

    repeat (5) @(negedge clk);
    expectValue("pending_bins", longint'(bin_q.size()), 0);
    expectValue("pending_peaks", longint'(peak_q.size()), 0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
